huffman_symbol_buffer: RTL and testbench

HUFFMAN_SYMBOL_BUFFER -- requirements
Module: huffman_symbol_buffer

---
 rtl/huff_pkg.sv | 68 ++++++
 rtl/huff_sym_fifo.sv | 69 ++++++
 rtl/huffman_symbol_buffer.sv | 105 ++++++++++
 tb/tb_huffman_symbol_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman symbol path: symbol encoding and the
// upstream code table, used by the buffer, the decoder and the bench.
package huff_pkg;

  localparam int SYM_W = 3;

  localparam logic [SYM_W-1:0] NO_SYM      = 3'b000;
  localparam logic [SYM_W-1:0] SYM_ILLEGAL = 3'b111;

  // Longest codeword in the table, in bits.
  localparam int CODE_MAX_LEN = 4;

  // Code table, right-aligned codewords: 1:"0" 2:"101" 3:"100" 4:"111"
  // 5:"1101" 6:"1100".
  localparam logic [CODE_MAX_LEN-1:0] CODE_1 = 4'b0000;
  localparam logic [CODE_MAX_LEN-1:0] CODE_2 = 4'b0101;
  localparam logic [CODE_MAX_LEN-1:0] CODE_3 = 4'b0100;
  localparam logic [CODE_MAX_LEN-1:0] CODE_4 = 4'b0111;
  localparam logic [CODE_MAX_LEN-1:0] CODE_5 = 4'b1101;
  localparam logic [CODE_MAX_LEN-1:0] CODE_6 = 4'b1100;

  localparam int CODE_LEN_1 = 1;
  localparam int CODE_LEN_2 = 3;
  localparam int CODE_LEN_3 = 3;
  localparam int CODE_LEN_4 = 3;
  localparam int CODE_LEN_5 = 4;
  localparam int CODE_LEN_6 = 4;

  // What a value on the decoder output bus means for the buffer.
  typedef enum logic [1:0] {
    Y_NONE    = 2'd0,
    Y_SYM     = 2'd1,
    Y_ILLEGAL = 2'd2
  } y_class_e;

  function automatic y_class_e classify_y(input logic [SYM_W-1:0] y);
    if (y == NO_SYM)           return Y_NONE;
    else if (y == SYM_ILLEGAL) return Y_ILLEGAL;
    else                       return Y_SYM;
  endfunction

  // Right-aligned codeword for a legal symbol (1..6); 0 otherwise.
  function automatic logic [CODE_MAX_LEN-1:0] code_bits(input logic [SYM_W-1:0] s);
    case (s)
      3'd1:    return CODE_1;
      3'd2:    return CODE_2;
      3'd3:    return CODE_3;
      3'd4:    return CODE_4;
      3'd5:    return CODE_5;
      3'd6:    return CODE_6;
      default: return '0;
    endcase
  endfunction

  // Codeword length for a legal symbol (1..6); 0 otherwise.
  function automatic int code_len(input logic [SYM_W-1:0] s);
    case (s)
      3'd1:    return CODE_LEN_1;
      3'd2:    return CODE_LEN_2;
      3'd3:    return CODE_LEN_3;
      3'd4:    return CODE_LEN_4;
      3'd5:    return CODE_LEN_5;
      3'd6:    return CODE_LEN_6;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/huff_sym_fifo.sv
// Symbol storage: DEPTH-entry circular FIFO with wrapping pointers and an
// occupancy count. push/pop arrive already qualified by the top; a push and a
// pop on the same edge are both honoured (the write goes to wr_ptr while the
// read leaves rd_ptr, so order is preserved even when full).
module huff_sym_fifo
  import huff_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [SYM_W-1:0] wr_data,
  output logic [SYM_W-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Next-state: write at wr_ptr, advance pointers (power-of-2 wrap), update level.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // State registers; reset empties the FIFO and clears storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Outputs decode registered state only; head reads as 0 when empty.
  always_comb begin
    level   = level_q;
    empty   = (level_q == '0);
    full    = (level_q == LVL_W'(DEPTH));
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/huffman_symbol_buffer.sv
// Buffers symbols from the serial Huffman decoder for a valid/ready consumer.
// Handshake: sym_valid is high whenever the FIFO holds a symbol; a transfer
// (pop) happens on any rising edge where sym_valid & sym_ready, and sym_data
// holds steady while sym_valid & ~sym_ready. y is only sampled at the clock
// edge, so no output depends combinationally on y.
module huffman_symbol_buffer
  import huff_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SYM_W-1:0]         y,
  input  logic                     clr_err,
  input  logic                     sym_ready,
  output logic                     sym_valid,
  output logic [SYM_W-1:0]         sym_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         sym_count,
  output logic                     overflow,
  output logic                     err_illegal
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("huffman_symbol_buffer: DEPTH must be a power of 2, at least 2");
  end

  y_class_e         y_class;
  logic             push_req;
  logic             push_acc;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [SYM_W-1:0] fifo_rd_data;
  logic [LVL_W-1:0] fifo_level;

  logic [CNT_W-1:0] sym_count_q, sym_count_d;
  logic             overflow_q, overflow_d;
  logic             err_illegal_q, err_illegal_d;

  // Classify y and qualify push/pop; a full FIFO still takes a push when it
  // is being popped on the same edge.
  always_comb begin
    y_class  = classify_y(y);
    push_req = (y_class == Y_SYM);
    pop      = ~fifo_empty & sym_ready;
    push_acc = push_req & (~fifo_full | pop);
  end

  huff_sym_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_acc),
    .pop     (pop),
    .wr_data (y),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Counter and sticky flags; a new error in the clr_err cycle wins the clear.
  always_comb begin
    sym_count_d   = sym_count_q;
    overflow_d    = overflow_q;
    err_illegal_d = err_illegal_q;
    if (push_acc) sym_count_d = sym_count_q + CNT_W'(1);
    if (clr_err) begin
      overflow_d    = 1'b0;
      err_illegal_d = 1'b0;
    end
    if (push_req & ~push_acc)     overflow_d    = 1'b1;
    if (y_class == Y_ILLEGAL)     err_illegal_d = 1'b1;
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_count_q   <= '0;
      overflow_q    <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      sym_count_q   <= sym_count_d;
      overflow_q    <= overflow_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  // Output mapping from registered state.
  always_comb begin
    sym_valid   = ~fifo_empty;
    sym_data    = fifo_rd_data;
    level       = fifo_level;
    sym_count   = sym_count_q;
    overflow    = overflow_q;
    err_illegal = err_illegal_q;
  end

endmodule

// File: tb/tb_huffman_symbol_buffer.sv
// Bench for huffman_symbol_buffer: directed vectors, expected symbols queued
// at issue time and checked by a monitor at each handshake.
`timescale 1ns/1ps
module tb_huffman_symbol_buffer;
  import huff_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic                   clk;
  logic                   reset;
  logic [2:0]             y;
  logic                   clr_err;
  logic                   sym_ready;
  logic                   sym_valid;
  logic [2:0]             sym_data;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       sym_count;
  logic                   overflow;
  logic                   err_illegal;

  logic [2:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  huffman_symbol_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .y           (y),
    .clr_err     (clr_err),
    .sym_ready   (sym_ready),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .level       (level),
    .sym_count   (sym_count),
    .overflow    (overflow),
    .err_illegal (err_illegal)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Driver: apply inputs, then return 1ns after the edge that consumes them.
  task automatic step(input logic [2:0] yv, input logic rdy, input logic clr);
    y = yv;
    sym_ready = rdy;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " sym_valid"}, sym_valid, 0);
    check({tag, " sym_data"}, sym_data, 0);
    check({tag, " level"}, level, 0);
    check({tag, " sym_count"}, sym_count, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " err_illegal"}, err_illegal, 0);
  endtask

  // Monitor / scoreboard: at each handshake the head must match the queue.
  always @(negedge clk) begin
    if (!reset && sym_valid && sym_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check("sym_data_order", sym_data, e);
      end
    end
  end

  // Watchdog
  initial begin
    repeat (20000) @(posedge clk);
    total++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : main
    logic [17:0] bits;
    logic [3:0]  acc;
    int          len;
    logic [2:0]  pending;

    reset = 1'b1; y = 3'd0; clr_err = 1'b0; sym_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    reset = 1'b0;

    // Two symbols, one cycle latency each.
    exp_q.push_back(3'd1);
    step(3'd1, 1'b1, 1'b0);
    check("lat_valid_1", sym_valid, 1);
    check("lat_data_1", sym_data, 1);
    step(3'd0, 1'b1, 1'b0);
    check("after_pop_valid", sym_valid, 0);
    exp_q.push_back(3'd5);
    step(3'd5, 1'b1, 1'b0);
    check("lat_valid_5", sym_valid, 1);
    step(3'd0, 1'b1, 1'b0);
    check("count_2", sym_count, 2);
    check("level_0", level, 0);

    // Fill with ready low; the fifth symbol is dropped.
    exp_q.push_back(3'd2); step(3'd2, 1'b0, 1'b0);
    exp_q.push_back(3'd3); step(3'd3, 1'b0, 1'b0);
    exp_q.push_back(3'd4); step(3'd4, 1'b0, 1'b0);
    exp_q.push_back(3'd6); step(3'd6, 1'b0, 1'b0);
    check("full_overflow_pre", overflow, 0);
    step(3'd1, 1'b0, 1'b0);
    check("full_level", level, 4);
    check("full_overflow", overflow, 1);
    check("full_head", sym_data, 2);
    check("full_count", sym_count, 6);
    step(3'd0, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 0);
    check("stall_head", sym_data, 2);

    // Full with simultaneous pop: push accepted.
    exp_q.push_back(3'd5);
    step(3'd5, 1'b1, 1'b0);
    check("pushpop_level", level, 4);
    check("pushpop_overflow", overflow, 0);
    check("pushpop_count", sym_count, 7);
    repeat (4) step(3'd0, 1'b1, 1'b0);
    check("drained_level", level, 0);

    // Illegal symbol and clear priority.
    exp_q.push_back(3'd3);
    step(3'd3, 1'b0, 1'b0);
    step(3'd7, 1'b0, 1'b0);
    check("illegal_flag", err_illegal, 1);
    check("illegal_level", level, 1);
    check("illegal_count", sym_count, 8);
    step(3'd0, 1'b0, 1'b1);
    check("illegal_cleared", err_illegal, 0);
    step(3'd7, 1'b0, 1'b1);
    check("illegal_wins_clr", err_illegal, 1);
    step(3'd0, 1'b0, 1'b1);
    check("illegal_cleared2", err_illegal, 0);
    step(3'd0, 1'b1, 1'b0);

    // Overflow in the same cycle as clr_err stays set.
    exp_q.push_back(3'd1); step(3'd1, 1'b0, 1'b0);
    exp_q.push_back(3'd2); step(3'd2, 1'b0, 1'b0);
    exp_q.push_back(3'd3); step(3'd3, 1'b0, 1'b0);
    exp_q.push_back(3'd4); step(3'd4, 1'b0, 1'b0);
    step(3'd5, 1'b0, 1'b1);
    check("ovf_wins_clr", overflow, 1);
    check("ovf_count", sym_count, 12);
    step(3'd0, 1'b0, 1'b1);
    check("ovf_cleared2", overflow, 0);
    repeat (4) step(3'd0, 1'b1, 1'b0);

    // End-to-end through a bit-serial decoder model: 0,101,100,111,1101,1100.
    for (int s = 1; s <= 6; s++) exp_q.push_back(3'(s));
    bits = 18'b0_101_100_111_1101_1100;
    acc = '0; len = 0; pending = 3'd0;
    for (int i = 17; i >= 0; i--) begin
      step(pending, 1'b1, 1'b0);
      pending = 3'd0;
      acc = {acc[2:0], bits[i]};
      len++;
      for (int s = 1; s <= 6; s++) begin
        if (len == code_len(3'(s)) && acc == code_bits(3'(s))) begin
          pending = 3'(s);
          acc = '0;
          len = 0;
        end
      end
    end
    step(pending, 1'b1, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    check("e2e_count", sym_count, 18);
    check("e2e_queue_empty", exp_q.size(), 0);

    // Reset mid-operation with three symbols buffered (discarded).
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    check("pre_reset_level", level, 3);
    y = 3'd4; sym_ready = 1'b1;
    reset = 1'b1;
    #1;
    check_idle_zero("async_reset");
    @(posedge clk);
    #1;
    check("reset_hold_level", level, 0);
    check("reset_hold_count", sym_count, 0);
    y = 3'd0;
    reset = 1'b0;

    // Counter wrap after 256 accepted pushes.
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(3'((i % 6) + 1));
      step(3'((i % 6) + 1), 1'b1, 1'b0);
      if (i == 254) check("count_255", sym_count, 255);
    end
    check("count_wrap", sym_count, 0);
    check("wrap_level", level, 1);
    step(3'd0, 1'b1, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    check("final_level", level, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
